// File: rtl/alul_pipe.sv
// alul_pipe: two-stage pipelined bitwise logic unit with valid/ready
// handshakes on both sides, an internal accumulator and result flags.
module alul_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       S,
    input  logic             ACC_SEL,
    input  logic             ACC_WR,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT,
    output logic             ZERO,
    output logic             PAR,
    output logic [CNT_W-1:0] OP_COUNT
);

    logic             s1_v_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [2:0]       s1_s_q;
    logic             s1_sel_q;
    logic             s1_wr_q;

    logic             s2_v_q;
    logic [WIDTH-1:0] out_q;
    logic             zero_q;
    logic             par_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic             s2_free;
    logic             xfer;
    logic             accept;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] res_d;

    assign s2_free  = !s2_v_q | OUT_READY;
    assign xfer     = s1_v_q & s2_free;
    assign IN_READY = !RST & (!s1_v_q | s2_free);
    assign accept   = IN_VALID & IN_READY;

    // ACC is read here, so a write on the previous transfer is already visible
    assign opa = s1_sel_q ? acc_q : s1_a_q;

    always_comb begin
        res_d = '0;
        unique case (s1_s_q)
            3'd0: res_d = opa & s1_b_q;
            3'd1: res_d = opa | s1_b_q;
            3'd2: res_d = opa ^ s1_b_q;
            3'd3: res_d = ~opa;
            3'd4: res_d = ~(opa & s1_b_q);
            3'd5: res_d = ~(opa | s1_b_q);
            3'd6: res_d = ~(opa ^ s1_b_q);
            3'd7: res_d = s1_b_q;
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_v_q   <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_s_q   <= '0;
            s1_sel_q <= 1'b0;
            s1_wr_q  <= 1'b0;
        end else if (accept) begin
            s1_v_q   <= 1'b1;
            s1_a_q   <= A;
            s1_b_q   <= B;
            s1_s_q   <= S;
            s1_sel_q <= ACC_SEL;
            s1_wr_q  <= ACC_WR;
        end else if (xfer) begin
            s1_v_q   <= 1'b0;
        end
    end

    // Result registers only load on a transfer, so they hold while stalled
    always_ff @(posedge CLK) begin
        if (RST) begin
            s2_v_q <= 1'b0;
            out_q  <= '0;
            zero_q <= 1'b0;
            par_q  <= 1'b0;
            acc_q  <= '0;
        end else if (xfer) begin
            s2_v_q <= 1'b1;
            out_q  <= res_d;
            zero_q <= (res_d == '0);
            par_q  <= ^res_d;
            if (s1_wr_q) begin
                acc_q <= res_d;
            end
        end else if (OUT_READY) begin
            s2_v_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (s2_v_q && OUT_READY) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign OUT_VALID = s2_v_q;
    assign OUT       = out_q;
    assign ZERO      = zero_q;
    assign PAR       = par_q;
    assign OP_COUNT  = cnt_q;

endmodule

// File: tb/tb_alul_pipe.sv
// tb_alul_pipe: scenario tasks against a queue-based reference model,
// plus a second instance for the WIDTH=16 / CNT_W=3 wrap case.
module tb_alul_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [2:0]  s = '0;
    logic        acc_sel = 1'b0;
    logic        acc_wr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out;
    logic        zero;
    logic        par;
    logic [15:0] op_count;

    logic        w_rst = 1'b1;
    logic        w_iv = 1'b0;
    logic        w_ir;
    logic [15:0] w_a = 16'h00FF;
    logic [15:0] w_b = 16'h0F0F;
    logic [2:0]  w_s = 3'd6;
    logic        w_ov;
    logic        w_or = 1'b1;
    logic [15:0] w_out;
    logic        w_zero;
    logic        w_par;
    logic [2:0]  w_cnt;

    int total = 0;
    int bad = 0;

    logic [7:0] expq[$];
    logic [9:0] obsq[$];
    logic [7:0] macc = '0;
    int inflight = 0;
    int nfired = 0;
    int nacc = 0;
    int hold_err = 0;
    int rdy_err = 0;
    logic held_v = 1'b0;
    logic [7:0] held = '0;

    always #5 clk = ~clk;

    alul_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .A(a), .B(b), .S(s), .ACC_SEL(acc_sel), .ACC_WR(acc_wr),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT(out),
        .ZERO(zero), .PAR(par), .OP_COUNT(op_count)
    );

    alul_pipe #(.WIDTH(16), .CNT_W(3)) dut_w (
        .CLK(clk), .RST(w_rst), .IN_VALID(w_iv), .IN_READY(w_ir),
        .A(w_a), .B(w_b), .S(w_s), .ACC_SEL(1'b0), .ACC_WR(1'b0),
        .OUT_VALID(w_ov), .OUT_READY(w_or), .OUT(w_out),
        .ZERO(w_zero), .PAR(w_par), .OP_COUNT(w_cnt)
    );

    function automatic logic [15:0] ref_op(input logic [2:0] op,
                                           input logic [15:0] x,
                                           input logic [15:0] y);
        case (op)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~x;
            3'd4: return ~(x & y);
            3'd5: return ~(x | y);
            3'd6: return ~(x ^ y);
            default: return y;
        endcase
    endfunction

    // One clock: log handshakes into model/observation queues, then advance
    task automatic tick();
        logic [15:0] r16;
        logic [7:0] av;
        bit acc_ev, fire_ev;
        #1;
        acc_ev  = in_valid && in_ready;
        fire_ev = out_valid && out_ready;
        if (rst && in_ready !== 1'b0) rdy_err++;
        if (!rst && in_ready !== !(inflight == 2 && !out_ready)) rdy_err++;
        if (held_v && (!out_valid || out !== held)) hold_err++;
        held_v = out_valid && !out_ready;
        held = out;
        if (acc_ev) begin
            av = acc_sel ? macc : a;
            r16 = ref_op(s, {8'h00, av}, {8'h00, b});
            if (acc_wr) macc = r16[7:0];
            expq.push_back(r16[7:0]);
            nacc++;
        end
        if (fire_ev) begin
            obsq.push_back({par, zero, out});
            nfired++;
        end
        inflight = inflight + int'(acc_ev) - int'(fire_ev);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && obsq.size() < expq.size(); i++) tick();
    endtask

    task automatic clear_q();
        expq.delete();
        obsq.delete();
    endtask

    task automatic do_reset();
        out_ready = 1'b0;
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_q();
        macc = '0;
        inflight = 0;
        nfired = 0;
        held_v = 1'b0;
    endtask

    task automatic beat(input logic [7:0] av, input logic [7:0] bv,
                        input logic [2:0] sv, input logic sel,
                        input logic wr);
        a = av;
        b = bv;
        s = sv;
        acc_sel = sel;
        acc_wr = wr;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        total++;
        if ({out_valid, out, zero, par, op_count} !== '0) begin
            bad++;
            $display("FAIL reset_state got=%b/%h/%b/%b/%0d want=0/00/0/0/0",
                     out_valid, out, zero, par, op_count);
        end
        do_reset();
    endtask

    task automatic test_latency();
        clear_q();
        beat(8'h12, 8'h34, 3'd1, 1'b0, 1'b0);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL lat_early got=%b want=0", out_valid);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out !== 8'h36) begin
            bad++;
            $display("FAIL lat_n1 got=%b/%h want=1/36", out_valid, out);
        end
        drain();
        clear_q();
    endtask

    task automatic test_ops();
        logic [7:0] want [8] = '{8'h05, 8'h0F, 8'h0A, 8'hF0,
                                 8'hFA, 8'hF0, 8'hF5, 8'h05};
        logic [7:0] w;
        clear_q();
        for (int i = 0; i < 8; i++) beat(8'h0F, 8'h05, 3'(i), 1'b0, 1'b0);
        drain();
        total++;
        if (obsq.size() != 8) begin
            bad++;
            $display("FAIL ops_n got=%0d want=8", obsq.size());
        end
        for (int i = 0; i < 8 && i < obsq.size(); i++) begin
            w = want[i];
            total++;
            if (obsq[i] !== {^w, w == 8'h00, w}) begin
                bad++;
                $display("FAIL op%0d got=%h want=%h", i, obsq[i],
                         {^w, w == 8'h00, w});
            end
        end
        clear_q();
    endtask

    task automatic test_flags();
        logic [9:0] want [3] = '{{1'b0, 1'b1, 8'h00},
                                 {1'b0, 1'b0, 8'hFF},
                                 {1'b1, 1'b0, 8'hFE}};
        clear_q();
        beat(8'h0F, 8'hF0, 3'd0, 1'b0, 1'b0);
        beat(8'h0F, 8'hF0, 3'd1, 1'b0, 1'b0);
        beat(8'h01, 8'hF0, 3'd3, 1'b0, 1'b0);
        drain();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= obsq.size() || obsq[i] !== want[i]) begin
                bad++;
                $display("FAIL flags%0d got=%h want=%h", i,
                         i < obsq.size() ? obsq[i] : 10'h3FF, want[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_acc_chain();
        logic [7:0] want [3] = '{8'h3C, 8'hC3, 8'hC3};
        clear_q();
        beat(8'h00, 8'h3C, 3'd7, 1'b0, 1'b1);
        beat(8'h00, 8'hFF, 3'd2, 1'b1, 1'b1);
        beat(8'h00, 8'hFF, 3'd0, 1'b1, 1'b0);
        drain();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= obsq.size() || obsq[i][7:0] !== want[i]) begin
                bad++;
                $display("FAIL acc%0d got=%h want=%h", i,
                         i < obsq.size() ? obsq[i][7:0] : 8'hxx, want[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_backpressure();
        bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int k = 0;
        int c = 0;
        int acc0;
        logic [7:0] av, bv;
        logic [2:0] sv;
        do_reset();
        hold_err = 0;
        rdy_err = 0;
        av = 8'($urandom);
        bv = 8'($urandom);
        sv = 3'($urandom);
        while (k < 6 && c < 100) begin
            a = av;
            b = bv;
            s = sv;
            acc_sel = 1'b0;
            acc_wr = 1'b0;
            in_valid = 1'b1;
            out_ready = pat[c % 6];
            acc0 = nacc;
            tick();
            c++;
            if (nacc != acc0) begin
                k++;
                av = 8'($urandom);
                bv = 8'($urandom);
                sv = 3'($urandom);
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 30 && obsq.size() < 6; i++) begin
            out_ready = pat[c % 6];
            tick();
            c++;
        end
        out_ready = 1'b0;
        total++;
        if (obsq.size() != 6 || expq.size() != 6) begin
            bad++;
            $display("FAIL bp_n got=%0d want=6", obsq.size());
        end
        for (int i = 0; i < 6 && i < obsq.size() && i < expq.size(); i++) begin
            total++;
            if (obsq[i] !== {^expq[i], expq[i] == 8'h00, expq[i]}) begin
                bad++;
                $display("FAIL bp%0d got=%h want=%h", i, obsq[i], expq[i]);
            end
        end
        total++;
        if (hold_err != 0 || rdy_err != 0) begin
            bad++;
            $display("FAIL bp_hold_ready got=%0d/%0d want=0/0",
                     hold_err, rdy_err);
        end
        total++;
        if (op_count !== 16'd6) begin
            bad++;
            $display("FAIL bp_count got=%0d want=6", op_count);
        end
        clear_q();
    endtask

    task automatic test_random();
        int n;
        clear_q();
        hold_err = 0;
        rdy_err = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom % 4) != 0;
            a = 8'($urandom);
            b = 8'($urandom);
            s = 3'($urandom);
            acc_sel = 1'($urandom);
            acc_wr = 1'($urandom);
            out_ready = ($urandom % 3) != 0;
            tick();
        end
        drain();
        total++;
        if (obsq.size() != expq.size()) begin
            bad++;
            $display("FAIL rnd_n got=%0d want=%0d", obsq.size(), expq.size());
        end
        n = 0;
        for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
            if (obsq[i] !== {^expq[i], expq[i] == 8'h00, expq[i]}) begin
                if (n < 5)
                    $display("FAIL rnd%0d got=%h want=%h", i, obsq[i], expq[i]);
                n++;
            end
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL rnd_data got=%0d want=0 wrong results", n);
        end
        total++;
        if (hold_err != 0 || rdy_err != 0) begin
            bad++;
            $display("FAIL rnd_hold_ready got=%0d/%0d want=0/0",
                     hold_err, rdy_err);
        end
        total++;
        if (op_count !== 16'(nfired)) begin
            bad++;
            $display("FAIL rnd_count got=%0d want=%0d", op_count, 16'(nfired));
        end
        clear_q();
    endtask

    task automatic test_reset_mid();
        clear_q();
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 8'h55;
        b = 8'hAA;
        s = 3'd1;
        acc_sel = 1'b0;
        acc_wr = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        total++;
        if (inflight != 2 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_full got=%0d/%b want=2/0", inflight, in_ready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_q();
        macc = '0;
        inflight = 0;
        nfired = 0;
        held_v = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out !== 8'h00 || op_count !== 16'd0) begin
            bad++;
            $display("FAIL mid_state got=%b/%h/%0d want=0/00/0",
                     out_valid, out, op_count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (obsq.size() != 0) begin
            bad++;
            $display("FAIL mid_stale got=%0d want=0 beats", obsq.size());
        end
        beat(8'h00, 8'hFF, 3'd0, 1'b1, 1'b0);
        drain();
        total++;
        if (obsq.size() != 1 || obsq[0][7:0] !== 8'h00) begin
            bad++;
            $display("FAIL mid_acc got=%h want=00",
                     obsq.size() > 0 ? obsq[0][7:0] : 8'hxx);
        end
        clear_q();
    endtask

    task automatic test_wrap();
        int sent = 0;
        int got = 0;
        w_rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        w_rst = 1'b0;
        w_or = 1'b1;
        for (int c = 0; c < 40; c++) begin
            w_iv = (sent < 9);
            #1;
            if (w_iv && w_ir) sent++;
            if (w_ov && w_or) begin
                got++;
                total++;
                if (w_out !== 16'hF00F || w_zero !== 1'b0 || w_par !== 1'b0) begin
                    bad++;
                    $display("FAIL wrap_out got=%h want=F00F", w_out);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        w_iv = 1'b0;
        total++;
        if (got != 9 || w_cnt !== 3'd1) begin
            bad++;
            $display("FAIL wrap_count got=%0d/%0d want=9/1", got, w_cnt);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_latency();
        test_ops();
        test_flags();
        test_acc_chain();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
